// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: bundle widths, field offsets inside each
// inter-stage bundle, and the state encoding of the skid-mode stage register.
package cpu_pipe_pkg;

    // EXE -> MEM bundle, LSB first: ctrl, rd, dram_wdata, dram_waddr, br_target, alu_result, pc
    localparam int unsigned EXE_MEM_W          = 170;
    localparam int unsigned EM_CTRL_LSB        = 0;
    localparam int unsigned EM_CTRL_W          = 5;
    localparam int unsigned EM_RD_LSB          = 5;
    localparam int unsigned EM_DRAM_WDATA_LSB  = 10;
    localparam int unsigned EM_DRAM_WADDR_LSB  = 42;
    localparam int unsigned EM_BR_TARGET_LSB   = 74;
    localparam int unsigned EM_ALU_RESULT_LSB  = 106;
    localparam int unsigned EM_PC_LSB          = 138;

    localparam int unsigned MEM_WB_W           = 71;
    localparam int unsigned MW_CTRL_LSB        = 0;
    localparam int unsigned MW_CTRL_W          = 2;
    localparam int unsigned MW_RD_LSB          = 2;
    localparam int unsigned MW_ALU_RESULT_LSB  = 7;
    localparam int unsigned MW_PC_LSB          = 39;

    localparam int unsigned ID_EXE_W           = 149;
    localparam int unsigned IE_CTRL_LSB        = 0;
    localparam int unsigned IE_CTRL_W          = 16;
    localparam int unsigned IE_RD_LSB          = 16;
    localparam int unsigned IE_BR_TARGET_LSB   = 21;
    localparam int unsigned IE_SRC2_LSB        = 53;
    localparam int unsigned IE_SRC1_LSB        = 85;
    localparam int unsigned IE_PC_LSB          = 117;

    localparam int unsigned REG_IDX_W          = 5;
    localparam int unsigned XLEN               = 32;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake and flush.
// SKID=0: single slot, pass-through ready. SKID=1: two entries, registered ready.
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = EXE_MEM_W,
    parameter bit          SKID  = 1'b0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             flush,
    output logic [1:0]       count
);

    generate
        if (SKID == 1'b0) begin : g_single
            logic             full_q, full_d;
            logic [WIDTH-1:0] data_q, data_d;
            logic             up_xfer, dn_xfer;

            assign in_ready  = (!full_q || out_ready) && !flush;
            assign out_valid = full_q && !flush;
            assign out_data  = data_q;
            assign count     = {1'b0, full_q};
            assign up_xfer   = in_valid && in_ready;
            assign dn_xfer   = out_valid && out_ready;

            // NOTE: every always_comb output gets a default first, so no path can infer a latch.
            always_comb begin
                full_d = full_q;
                data_d = data_q;
                if (flush) begin
                    full_d = 1'b0;
                end else if (up_xfer) begin
                    full_d = 1'b1;
                    data_d = in_data;
                end else if (dn_xfer) begin
                    full_d = 1'b0;
                end
            end

            // NOTE: sequential state uses non-blocking assignments only; blocking here races other flops.
            // NOTE: the payload register is reset too, so out_data reads 0 out of reset.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    full_q <= 1'b0;
                    data_q <= '0;
                end else begin
                    full_q <= full_d;
                    data_q <= data_d;
                end
            end
        end else begin : g_skid
            skid_state_e      state_q, state_d;
            logic [WIDTH-1:0] main_q, main_d;
            logic [WIDTH-1:0] skid_q, skid_d;
            logic             up_xfer, dn_xfer;

            // Ready depends only on registered state, breaking the out_ready -> in_ready path.
            assign in_ready  = (state_q != SKID_TWO) && !flush;
            assign out_valid = ((state_q == SKID_ONE) || (state_q == SKID_TWO)) && !flush;
            assign out_data  = main_q;
            assign count     = state_q;
            assign up_xfer   = in_valid && in_ready;
            assign dn_xfer   = out_valid && out_ready;

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                if (flush) begin
                    state_d = SKID_EMPTY;
                end else begin
                    case (state_q)
                        SKID_EMPTY: begin
                            if (up_xfer) begin
                                state_d = SKID_ONE;
                                main_d  = in_data;
                            end
                        end
                        SKID_ONE: begin
                            case ({up_xfer, dn_xfer})
                                2'b10: begin
                                    state_d = SKID_TWO;
                                    skid_d  = in_data;
                                end
                                2'b01:   state_d = SKID_EMPTY;
                                2'b11:   main_d  = in_data;
                                default: state_d = SKID_ONE;
                            endcase
                        end
                        SKID_TWO: begin
                            if (dn_xfer) begin
                                state_d = SKID_ONE;
                                main_d  = skid_q;
                            end
                        end
                        default: state_d = SKID_EMPTY;
                    endcase
                end
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    state_q <= SKID_EMPTY;
                    main_q  <= '0;
                    skid_q  <= '0;
                end else begin
                    state_q <= state_d;
                    main_q  <= main_d;
                    skid_q  <= skid_d;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: both modes side by side at WIDTH=170,
// with a queue scoreboard per instance plus a table of directed corner cases.
module tb_pipe_stage_reg;

    localparam int W = 170;
    typedef logic [W-1:0] data_t;

    typedef struct {
        int         m;
        logic       iv;
        data_t      d;
        logic       ordy;
        logic       fl;
        logic [1:0] e_cnt;
        logic       e_ir;
        logic       e_ov;
        data_t      e_od;
    } vec_t;

    logic       clk;
    logic       resetn;
    logic [1:0] in_valid;
    logic [1:0] out_ready;
    logic [1:0] flush;
    data_t      in_data [2];

    logic       ir0, ov0, ir1, ov1;
    data_t      od0, od1;
    logic [1:0] cnt0, cnt1;

    int errors = 0;
    int checks = 0;

    data_t sb0[$];
    data_t sb1[$];
    vec_t  vq[$];

    pipe_stage_reg #(.WIDTH(W), .SKID(1'b0)) u_dut0 (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid[0]),
        .in_data   (in_data[0]),
        .in_ready  (ir0),
        .out_valid (ov0),
        .out_data  (od0),
        .out_ready (out_ready[0]),
        .flush     (flush[0]),
        .count     (cnt0)
    );

    pipe_stage_reg #(.WIDTH(W), .SKID(1'b1)) u_dut1 (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid[1]),
        .in_data   (in_data[1]),
        .in_ready  (ir1),
        .out_valid (ov1),
        .out_data  (od1),
        .out_ready (out_ready[1]),
        .flush     (flush[1]),
        .count     (cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input data_t act, input data_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: the queue is the reference model; its size is the expected occupancy.
    task automatic monitor(input int m, input logic ov, input logic ir,
                           input logic [1:0] cnt, input data_t od);
        data_t q[$];
        logic  e_ir, e_ov;
        if (m == 0) q = sb0; else q = sb1;
        if (!resetn) q.delete();
        if (m == 0) e_ir = ((q.size() == 0) || out_ready[m]) && !flush[m];
        else        e_ir = (q.size() < 2) && !flush[m];
        e_ov = (q.size() > 0) && !flush[m];
        check($sformatf("m%0d.count", m), data_t'(cnt), data_t'(q.size()));
        check($sformatf("m%0d.in_ready", m), data_t'(ir), data_t'(e_ir));
        check($sformatf("m%0d.out_valid", m), data_t'(ov), data_t'(e_ov));
        if (e_ov) check($sformatf("m%0d.out_data", m), od, q[0]);
        if (resetn) begin
            if (flush[m]) begin
                q.delete();
            end else begin
                if (e_ov && out_ready[m]) void'(q.pop_front());
                if (e_ir && in_valid[m])  q.push_back(in_data[m]);
            end
        end
        if (m == 0) sb0 = q; else sb1 = q;
    endtask

    always @(negedge clk) begin
        monitor(0, ov0, ir0, cnt0, od0);
        monitor(1, ov1, ir1, cnt1, od1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 2'b00;
        out_ready = 2'b11;
        flush     = 2'b00;
    endtask

    task automatic add(input int m, input logic iv, input data_t d, input logic ordy,
                       input logic fl, input logic [1:0] e_cnt, input logic e_ir,
                       input logic e_ov, input data_t e_od);
        vec_t v;
        v.m = m; v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.e_cnt = e_cnt; v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od;
        vq.push_back(v);
    endtask

    initial begin
        data_t r;
        logic [15:0] seq;
        // Skid mode: back-pressure absorbs two beats, then drains in order.
        add(1, 1, 'h11, 0, 0, 2'd0, 1, 0, 'h0);
        add(1, 1, 'h22, 0, 0, 2'd1, 1, 1, 'h11);
        add(1, 1, 'h33, 0, 0, 2'd2, 0, 1, 'h11);
        add(1, 1, 'h33, 1, 0, 2'd2, 0, 1, 'h11);
        add(1, 1, 'h33, 1, 0, 2'd1, 1, 1, 'h22);
        add(1, 0, 'h0,  1, 0, 2'd1, 1, 1, 'h33);
        add(1, 0, 'h0,  0, 0, 2'd0, 1, 0, 'h0);
        // Skid mode: flush in TWO while 0x55 is offered.
        add(1, 1, 'h44, 0, 0, 2'd0, 1, 0, 'h0);
        add(1, 1, 'h45, 0, 0, 2'd1, 1, 1, 'h44);
        add(1, 1, 'h55, 0, 1, 2'd2, 0, 0, 'h0);
        add(1, 0, 'h0,  1, 0, 2'd0, 1, 0, 'h0);
        // Single slot: simultaneous replace, same-cycle stall, flush while full.
        add(0, 1, 'hA,  0, 0, 2'd0, 1, 0, 'h0);
        add(0, 1, 'hB,  1, 0, 2'd1, 1, 1, 'hA);
        add(0, 0, 'h0,  0, 0, 2'd1, 0, 1, 'hB);
        add(0, 1, 'hC,  0, 0, 2'd1, 0, 1, 'hB);
        add(0, 0, 'h0,  0, 0, 2'd1, 0, 1, 'hB);
        add(0, 1, 'hD,  1, 1, 2'd1, 0, 0, 'h0);
        add(0, 0, 'h0,  1, 0, 2'd0, 1, 0, 'h0);

        resetn     = 1'b1;
        in_valid   = 2'b00;
        out_ready  = 2'b00;
        flush      = 2'b00;
        in_data[0] = '0;
        in_data[1] = '0;
        #2 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        @(negedge clk);
        check("rst.ov0", data_t'(ov0), '0);
        check("rst.ov1", data_t'(ov1), '0);
        check("rst.cnt0", data_t'(cnt0), '0);
        check("rst.cnt1", data_t'(cnt1), '0);
        check("rst.ir0", data_t'(ir0), data_t'(1));
        check("rst.ir1", data_t'(ir1), data_t'(1));
        check("rst.od0", od0, '0);
        check("rst.od1", od1, '0);

        tick();
        in_valid   = 2'b11;
        in_data[0] = data_t'(32'hDEADBEEF);
        in_data[1] = data_t'(32'hDEADBEEF);
        tick();
        in_valid = 2'b00;
        @(negedge clk);
        check("fill.ov0", data_t'(ov0), data_t'(1));
        check("fill.ov1", data_t'(ov1), data_t'(1));
        check("fill.od0", od0, data_t'(32'hDEADBEEF));
        check("fill.od1", od1, data_t'(32'hDEADBEEF));
        check("fill.cnt0", data_t'(cnt0), data_t'(1));
        check("fill.cnt1", data_t'(cnt1), data_t'(1));
        tick();
        idle();
        repeat (2) tick();

        for (int i = 0; i < vq.size(); i++) begin
            idle();
            in_valid[vq[i].m]  = vq[i].iv;
            in_data[vq[i].m]   = vq[i].d;
            out_ready[vq[i].m] = vq[i].ordy;
            flush[vq[i].m]     = vq[i].fl;
            @(negedge clk);
            if (vq[i].m == 0) begin
                check($sformatf("vec%0d.count", i), data_t'(cnt0), data_t'(vq[i].e_cnt));
                check($sformatf("vec%0d.in_ready", i), data_t'(ir0), data_t'(vq[i].e_ir));
                check($sformatf("vec%0d.out_valid", i), data_t'(ov0), data_t'(vq[i].e_ov));
                if (vq[i].e_ov) check($sformatf("vec%0d.out_data", i), od0, vq[i].e_od);
            end else begin
                check($sformatf("vec%0d.count", i), data_t'(cnt1), data_t'(vq[i].e_cnt));
                check($sformatf("vec%0d.in_ready", i), data_t'(ir1), data_t'(vq[i].e_ir));
                check($sformatf("vec%0d.out_valid", i), data_t'(ov1), data_t'(vq[i].e_ov));
                if (vq[i].e_ov) check($sformatf("vec%0d.out_data", i), od1, vq[i].e_od);
            end
            tick();
        end

        // Async reset between edges with the skid instance in TWO.
        idle();
        out_ready  = 2'b00;
        in_valid   = 2'b11;
        in_data[0] = data_t'(32'h66);
        in_data[1] = data_t'(32'h66);
        tick();
        in_data[0] = data_t'(32'h77);
        in_data[1] = data_t'(32'h77);
        tick();
        in_valid = 2'b00;
        #2 resetn = 1'b0;
        #1;
        check("arst.ov0", data_t'(ov0), '0);
        check("arst.ov1", data_t'(ov1), '0);
        check("arst.cnt0", data_t'(cnt0), '0);
        check("arst.cnt1", data_t'(cnt1), '0);
        @(posedge clk);
        #1 resetn = 1'b1;

        // Random soak on both instances; the scoreboard checks order, loss and hold stability.
        seq = '0;
        for (int c = 0; c < 10000; c++) begin
            for (int m = 0; m < 2; m++) begin
                r = '0;
                for (int k = 0; k < 6; k++) r = {r[W-33:0], 32'($urandom())};
                r[15:0]      = seq;
                seq          = seq + 16'd1;
                in_data[m]   = r;
                in_valid[m]  = ($urandom_range(0, 3) != 0);
                out_ready[m] = ($urandom_range(0, 2) != 0);
                flush[m]     = ($urandom_range(0, 63) == 0);
            end
            tick();
        end
        idle();
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
